shift_seq_univ: RTL and testbench
=================================

# shift_seq_univ

Parametrised universal shift register with a multi-cycle shift-by-N sequencer. Retains the direct per-cycle S1/S0 modes (hold, shift right, shift left, parallel load) and adds logical, arithmetic, rotate and serial-fill shifts by a programmable amount, with busy/done handshake. Sits in the datapath framework as the general shift/rotate unit for ALU and serial-conversion use.

## Interface

- WIDTH, 32, register width in bits (≥2)
- AMT_W, 6, width of shift-amount input (amount range 0..2^AMT_W−1)

- clk  input  1  clock, all state updates on rising edge
- clear  input  1  reset, synchronous, active-high
- S1, S0  input  1 each  direct mode: 00 hold, 01 shift right, 10 shift left, 11 load PData
- SR  input  1  serial input entering MSB on right shift
- SL  input  1  serial input entering LSB on left shift
- PData  input  WIDTH  parallel load data
- start  input  1  launch sequenced shift (sampled only when idle)
- amt  input  AMT_W  shift amount for sequenced shift
- dir  input  1  0 right, 1 left
- kind  input  2  00 logical, 01 arithmetic, 10 rotate, 11 serial fill
- Q  output  WIDTH  register contents
- SO_R  output  1  Q[0] (combinational)
- SO_L  output  1  Q[WIDTH−1] (combinational)
- busy  output  1  sequenced shift in progress
- done  output  1  one-cycle pulse, sequenced shift complete

## Operation

- Reset is synchronous and active-high on clear; one clock, clk. Reset values: Q=0, busy=0, done=0, internal counter=0, state IDLE.
- States: IDLE, BUSY.
- IDLE, start=0: S1/S0 applied each edge. Right shift: Q <= {SR, Q[WIDTH−1:1]}. Left shift: Q <= {Q[WIDTH−2:0], SL}.
- IDLE, start=1: start has priority over S1/S0 (S1/S0 ignored that edge). amt, dir, kind latched.
  - amt=0: stay IDLE, Q unchanged, done=1 next cycle.
  - amt>0: go BUSY, counter=amt, Q unchanged this edge.
- BUSY: one 1-bit shift per edge, counter decrements. Fill bit per kind:
  - logical: 0.
  - arithmetic: right fills Q[WIDTH−1] (sign); left identical to logical.
  - rotate: right fills Q[0]; left fills Q[WIDTH−1].
  - serial: right fills live SR, left fills live SL, sampled each shift edge.
- On the edge where counter goes 1→0: final shift performed, state → IDLE, done=1 for the following cycle.
- BUSY ignores start, S1/S0, amt, dir and kind (latched copies used).
- amt ≥ WIDTH is legal: exactly amt shifts performed. Logical result is 0; rotate wraps modulo WIDTH; arithmetic result is all sign bits.
- done deasserts after one cycle unconditionally. A new start is accepted in the same cycle done is high (state is IDLE).
- clear while BUSY: abort, reset values applied, no done pulse.

## Timing

- Start sampled at edge k with amt=N>0: busy high from after edge k through edge k+N.
- Shifts occur at edges k+1..k+N. done is high in the cycle after edge k+N. Total latency: N+1 edges to done.
- amt=0: done high in the cycle after edge k; busy never asserted.
- Direct modes: 1-edge latency, Q updated at the sampling edge.
- SO_R and SO_L track Q combinationally, with zero latency.

## Configuration

- SHIFT_BARREL_EN defined: sequenced shifts are combinational barrel shifts.
  - At start edge k, Q receives the complete N-bit shifted result.
  - done is high in the cycle after edge k; busy is never asserted; the BUSY state is not built.
  - Serial kind fills all N vacated bits with the SR or SL value sampled at edge k.
  - For amt ≥ WIDTH, results match the sequential mode for logical, arithmetic and rotate.
- SHIFT_BARREL_EN undefined: 1-bit-per-cycle sequencer as described above (default).

## Test plan

- Reset/direct: clear=1 then Q=0. Load PData=0 (S1S0=11), then S1S0=01, SR=1 for 1 edge → Q=0x8000_0000; S1S0=10, SL=1 for 1 edge → Q=0x0000_0001.
- Arithmetic right: load 0x8000_0001, start kind=01 dir=0 amt=4 → busy for 4 cycles, then Q=0xF800_0000, done pulses exactly once.
- Rotate left: load 0x1234_5678, kind=10 dir=1 amt=8 → Q=0x3456_7812, done 9 edges after start. Repeat with amt=40 → same result.
- Edge amounts: logical left amt=33 on 0xFFFF_FFFF → Q=0. amt=0 → done next cycle, Q unchanged, busy stays 0.
- Abort/ignore: start amt=10. Toggle S1S0=11 and start during BUSY → ignored. clear at 3rd busy cycle → Q=0, busy=0, no done.
- Serial fill: Q=0, kind=11 dir=0 amt=4, SR driven 1,0,1,1 on successive shift edges → Q[31:28]=4'b1101.

Source files
------------

// File: rtl/shift_seq_univ.sv
// Universal shift register with direct S1/S0 modes plus a shift-by-N sequencer (logical/arith/rotate/serial).
// Optional macro SHIFT_BARREL_EN: sequenced shifts finish in one edge through a barrel shifter; otherwise 1 bit per cycle.
module shift_seq_univ #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 6
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             S1,
    input  logic             S0,
    input  logic             SR,
    input  logic             SL,
    input  logic [WIDTH-1:0] PData,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir,
    input  logic [1:0]       kind,
    output logic [WIDTH-1:0] Q,
    output logic             SO_R,
    output logic             SO_L,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] K_LOG = 2'b00;
    localparam logic [1:0] K_ARI = 2'b01;
    localparam logic [1:0] K_ROT = 2'b10;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_direct;
    logic             r_done;
    logic             w_done_next;

    assign Q    = r_q;
    assign SO_R = r_q[0];
    assign SO_L = r_q[WIDTH-1];
    assign done = r_done;

    always_comb begin
        w_direct = r_q;
        case ({S1, S0})
            2'b01:   w_direct = {SR, r_q[WIDTH-1:1]};
            2'b10:   w_direct = {r_q[WIDTH-2:0], SL};
            2'b11:   w_direct = PData;
            default: w_direct = r_q;
        endcase
    end

`ifdef SHIFT_BARREL_EN
    int               w_rot;
    logic [2*WIDTH-1:0] w_rotl;
    logic [2*WIDTH-1:0] w_rotr;
    logic [WIDTH-1:0] w_vac;
    logic [WIDTH-1:0] w_barrel;

    assign busy = 1'b0;

    // Rotation is taken modulo WIDTH; other kinds let oversized shifts drain naturally.
    always_comb begin
        w_rot  = int'(amt) % WIDTH;
        w_rotl = {r_q, r_q} << w_rot;
        w_rotr = {r_q, r_q} >> w_rot;
        w_vac  = dir ? ~({WIDTH{1'b1}} << amt) : ~({WIDTH{1'b1}} >> amt);
        case (kind)
            K_LOG:   w_barrel = dir ? (r_q << amt) : (r_q >> amt);
            K_ARI:   w_barrel = dir ? (r_q << amt) : $unsigned($signed(r_q) >>> amt);
            K_ROT:   w_barrel = dir ? w_rotl[2*WIDTH-1:WIDTH] : w_rotr[WIDTH-1:0];
            default: w_barrel = dir ? ((r_q << amt) | (SL ? w_vac : '0))
                                    : ((r_q >> amt) | (SR ? w_vac : '0));
        endcase
    end

    always_comb begin
        w_q_next    = w_direct;
        w_done_next = 1'b0;
        if (start) begin
            w_q_next    = w_barrel;
            w_done_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_q    <= '0;
            r_done <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_done <= w_done_next;
        end
    end
`else
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           r_state, w_state_next;
    logic [AMT_W-1:0] r_cnt, w_cnt_next;
    logic             r_dir, w_dir_next;
    logic [1:0]       r_kind, w_kind_next;
    logic             w_fill;
    logic [WIDTH-1:0] w_step;

    assign busy = (r_state == BUSY);

    // Fill bit uses the latched kind/dir; serial kind samples live SR/SL.
    always_comb begin
        case (r_kind)
            K_LOG:   w_fill = 1'b0;
            K_ARI:   w_fill = r_dir ? 1'b0 : r_q[WIDTH-1];
            K_ROT:   w_fill = r_dir ? r_q[WIDTH-1] : r_q[0];
            default: w_fill = r_dir ? SL : SR;
        endcase
        w_step = r_dir ? {r_q[WIDTH-2:0], w_fill} : {w_fill, r_q[WIDTH-1:1]};
    end

    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_cnt_next   = r_cnt;
        w_dir_next   = r_dir;
        w_kind_next  = r_kind;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_dir_next  = dir;
                    w_kind_next = kind;
                    if (amt == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = BUSY;
                        w_cnt_next   = amt;
                    end
                end else begin
                    w_q_next = w_direct;
                end
            end
            default: begin
                w_q_next   = w_step;
                w_cnt_next = r_cnt - AMT_W'(1);
                if (r_cnt == AMT_W'(1)) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_kind  <= 2'b00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_cnt   <= w_cnt_next;
            r_dir   <= w_dir_next;
            r_kind  <= w_kind_next;
            r_done  <= w_done_next;
        end
    end
`endif
endmodule

// File: tb/tb_shift_seq_univ.sv
// Directed bench for shift_seq_univ: vector table for direct/short sequences, hand sequences for long runs.
module tb_shift_seq_univ;
    localparam int W  = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          clear, S1, S0, SR, SL, start, dir;
    logic [W-1:0]  PData;
    logic [AW-1:0] amt;
    logic [1:0]    kind;
    logic [W-1:0]  Q;
    logic          SO_R, SO_L, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    shift_seq_univ #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk(clk), .clear(clear), .S1(S1), .S0(S0), .SR(SR), .SL(SL),
        .PData(PData), .start(start), .amt(amt), .dir(dir), .kind(kind),
        .Q(Q), .SO_R(SO_R), .SO_L(SO_L), .busy(busy), .done(done)
    );

    typedef struct {
        logic          clr;
        logic [1:0]    s;
        logic          sr;
        logic          sl;
        logic [W-1:0]  pd;
        logic          st;
        logic [AW-1:0] a;
        logic          d;
        logic [1:0]    k;
        logic [W-1:0]  eq;
        logic          eb;
        logic          ed;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic clr, logic [1:0] s, logic sr, logic sl, logic [W-1:0] pd,
                                logic st, logic [AW-1:0] a, logic d, logic [1:0] k,
                                logic [W-1:0] eq, logic eb, logic ed);
        vec_t v;
        v.clr = clr; v.s = s; v.sr = sr; v.sl = sl; v.pd = pd; v.st = st;
        v.a = a; v.d = d; v.k = k; v.eq = eq; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic drive(logic clr, logic [1:0] s, logic sr, logic sl, logic [W-1:0] pd,
                         logic st, logic [AW-1:0] a, logic d, logic [1:0] k);
        clear = clr; {S1, S0} = s; SR = sr; SL = sl; PData = pd;
        start = st; amt = a; dir = d; kind = k;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 2'b00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk(string nm, logic [W-1:0] eq, logic eb, logic ed);
        chk1({nm, ".Q"}, Q, eq);
        chk1({nm, ".busy"}, W'(busy), W'(eb));
        chk1({nm, ".done"}, W'(done), W'(ed));
        chk1({nm, ".SO"}, W'({SO_L, SO_R}), W'({eq[W-1], eq[0]}));
        $display("%s: Q=%h busy=%0b done=%0b", nm, Q, busy, done);
    endtask

    // Load a value, launch a sequenced shift, and follow it edge by edge to done.
    task automatic run_seq(string nm, logic [W-1:0] init, logic [AW-1:0] a, logic d,
                           logic [1:0] k, logic [W-1:0] fin);
        drive(1'b0, 2'b11, 1'b0, 1'b0, init, 1'b0, '0, 1'b0, 2'b00);
        tick();
        drive(1'b0, 2'b00, 1'b0, 1'b0, '0, 1'b1, a, d, k);
        tick();
        chk({nm, ".start"}, init, 1'b1, 1'b0);
        idle();
        for (int i = 1; i < int'(a); i++) begin
            tick();
            chk1($sformatf("%s.busy%0d", nm, i), W'({busy, done}), W'(2'b10));
        end
        tick();
        chk({nm, ".final"}, fin, 1'b0, 1'b1);
        tick();
        chk({nm, ".after"}, fin, 1'b0, 1'b0);
    endtask

    initial begin
        tbl[0]  = mk(1, 2'b00, 0, 0, 32'h0,         0, 0, 0, 2'b00, 32'h0,         0, 0);
        tbl[1]  = mk(0, 2'b11, 0, 0, 32'h0,         0, 0, 0, 2'b00, 32'h0,         0, 0);
        tbl[2]  = mk(0, 2'b01, 1, 0, 32'h0,         0, 0, 0, 2'b00, 32'h8000_0000, 0, 0);
        tbl[3]  = mk(0, 2'b10, 0, 1, 32'h0,         0, 0, 0, 2'b00, 32'h0000_0001, 0, 0);
        tbl[4]  = mk(0, 2'b00, 1, 1, 32'h0,         0, 0, 0, 2'b00, 32'h0000_0001, 0, 0);
        tbl[5]  = mk(0, 2'b11, 0, 0, 32'h8000_0001, 0, 0, 0, 2'b00, 32'h8000_0001, 0, 0);
        tbl[6]  = mk(0, 2'b10, 0, 1, 32'h0,         1, 4, 0, 2'b01, 32'h8000_0001, 1, 0);
        tbl[7]  = mk(0, 2'b00, 0, 0, 32'h0,         0, 0, 0, 2'b00, 32'hC000_0000, 1, 0);
        tbl[8]  = mk(0, 2'b00, 0, 0, 32'h0,         0, 0, 0, 2'b00, 32'hE000_0000, 1, 0);
        tbl[9]  = mk(0, 2'b00, 0, 0, 32'h0,         0, 0, 0, 2'b00, 32'hF000_0000, 1, 0);
        tbl[10] = mk(0, 2'b00, 0, 0, 32'h0,         0, 0, 0, 2'b00, 32'hF800_0000, 0, 1);
        tbl[11] = mk(0, 2'b01, 1, 0, 32'h0,         1, 0, 0, 2'b00, 32'hF800_0000, 0, 1);
        tbl[12] = mk(0, 2'b00, 0, 0, 32'h0,         0, 0, 0, 2'b00, 32'hF800_0000, 0, 0);

        idle();
        clear = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].clr, tbl[i].s, tbl[i].sr, tbl[i].sl, tbl[i].pd,
                  tbl[i].st, tbl[i].a, tbl[i].d, tbl[i].k);
            tick();
            chk($sformatf("vec%0d", i), tbl[i].eq, tbl[i].eb, tbl[i].ed);
        end

        run_seq("rotl8",  32'h1234_5678, 6'd8,  1'b1, 2'b10, 32'h3456_7812);
        run_seq("rotl40", 32'h1234_5678, 6'd40, 1'b1, 2'b10, 32'h3456_7812);
        run_seq("logl33", 32'hFFFF_FFFF, 6'd33, 1'b1, 2'b00, 32'h0);
        run_seq("rotr4",  32'h0000_00AB, 6'd4,  1'b0, 2'b10, 32'hB000_000A);

        // Abort: inputs toggled during BUSY are ignored, clear on the 3rd busy cycle kills the run.
        drive(1'b0, 2'b11, 1'b0, 1'b0, 32'hF000_000F, 1'b0, '0, 1'b0, 2'b00);
        tick();
        drive(1'b0, 2'b00, 1'b0, 1'b0, '0, 1'b1, 6'd10, 1'b0, 2'b00);
        tick();
        chk("abort.start", 32'hF000_000F, 1'b1, 1'b0);
        drive(1'b0, 2'b11, 1'b1, 1'b1, 32'h0, 1'b1, 6'd1, 1'b1, 2'b10);
        tick();
        chk("abort.b1", 32'h7800_0007, 1'b1, 1'b0);
        tick();
        chk("abort.b2", 32'h3C00_0003, 1'b1, 1'b0);
        idle();
        clear = 1'b1;
        tick();
        chk("abort.clr", 32'h0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1($sformatf("abort.quiet%0d", i), W'({busy, done}), W'(2'b00));
        end

        // Serial fill right with SR changing on every shift edge.
        drive(1'b0, 2'b00, 1'b0, 1'b0, '0, 1'b1, 6'd4, 1'b0, 2'b11);
        tick();
        chk("ser.start", 32'h0, 1'b1, 1'b0);
        idle(); SR = 1'b1;
        tick();
        chk("ser.s1", 32'h8000_0000, 1'b1, 1'b0);
        SR = 1'b0;
        tick();
        chk("ser.s2", 32'h4000_0000, 1'b1, 1'b0);
        SR = 1'b1;
        tick();
        chk("ser.s3", 32'hA000_0000, 1'b1, 1'b0);
        SR = 1'b1;
        tick();
        chk("ser.s4", 32'hD000_0000, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
